// File: rtl/vip_gray_pixel_packer.sv
// Gray pixel packer: groups four filtered 8-bit pixels into 32-bit words,
// tags frame start / line end, and buffers the words in a first-word-fall-
// through FIFO behind a valid/ready master port. Dropped words are counted.
module vip_gray_pixel_packer #(
  parameter logic [9:0] IMG_HDISP  = 10'd640,
  parameter logic [9:0] IMG_VDISP  = 10'd480,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Y,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        frame_done,
  output logic [15:0] ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Packing state. 'armed' keeps packing off until a vsync rising edge has
  // been seen since reset.
  logic        vsync_p1;
  logic        href_p1;
  logic        armed;
  logic [1:0]  lane;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [23:0] pack;

  logic        vs_rise;
  logic        pix_ok;
  logic        href_fall;

  logic        push_req;
  logic [31:0] push_data;
  logic        push_user;
  logic        push_last;

  // FIFO storage: {tuser, tlast, tdata}; pointers carry one wrap bit.
  logic [33:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_write;
  logic [33:0] head;

  assign vs_rise   = per_frame_vsync && !vsync_p1;
  assign pix_ok    = armed && !vs_rise && per_frame_vsync && per_frame_href && per_frame_clken;
  assign href_fall = armed && !vs_rise && href_p1 && !per_frame_href;

  // Decide whether a word leaves the packer this cycle and what it contains.
  always_comb begin
    push_req  = 1'b0;
    push_data = 32'd0;
    push_user = 1'b0;
    push_last = 1'b0;
    if (pix_ok && lane == 2'd3) begin
      push_req  = 1'b1;
      push_data = {per_img_Y, pack};
      push_user = (y == 10'd0) && (x == 10'd3);
      push_last = (x == IMG_HDISP - 10'd1);
    end else if (href_fall && lane != 2'd0) begin
      // Short line: unused upper lanes are zero-padded.
      push_req  = 1'b1;
      push_user = (y == 10'd0) && (x < 10'd4);
      push_last = 1'b1;
      case (lane)
        2'd1:    push_data = {24'd0, pack[7:0]};
        2'd2:    push_data = {16'd0, pack[15:0]};
        default: push_data = {8'd0, pack[23:0]};
      endcase
    end
  end

  // Position counters, edge-detect history, frame-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1   <= 1'b0;
      href_p1    <= 1'b0;
      armed      <= 1'b0;
      lane       <= 2'd0;
      x          <= 10'd0;
      y          <= 10'd0;
      frame_done <= 1'b0;
    end else begin
      vsync_p1   <= per_frame_vsync;
      href_p1    <= per_frame_href;
      frame_done <= push_req && push_last && (y == IMG_VDISP - 10'd1);
      if (vs_rise) begin
        armed <= 1'b1;
        lane  <= 2'd0;
        x     <= 10'd0;
        y     <= 10'd0;
      end else if (pix_ok) begin
        if (x == IMG_HDISP - 10'd1) begin
          x    <= 10'd0;
          lane <= 2'd0;
          if (y != IMG_VDISP - 10'd1) y <= y + 10'd1;
        end else begin
          x    <= x + 10'd1;
          lane <= lane + 2'd1;
        end
      end else if (href_fall && (lane != 2'd0 || x != 10'd0)) begin
        x    <= 10'd0;
        lane <= 2'd0;
        if (y != IMG_VDISP - 10'd1) y <= y + 10'd1;
      end
    end
  end

  // Byte-lane capture for the first three pixels of a group.
  always_ff @(posedge clk) begin
    if (pix_ok) begin
      case (lane)
        2'd0:    pack[7:0]   <= per_img_Y;
        2'd1:    pack[15:8]  <= per_img_Y;
        2'd2:    pack[23:16] <= per_img_Y;
        default: pack        <= pack;
      endcase
    end
  end

  // ---- stage boundary: packer -> FIFO ----
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = !empty && m_tready;
  assign do_write = push_req && (!full || do_pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= {push_user, push_last, push_data};
  end

  // FIFO pointers and saturating overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_cnt <= 16'd0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_req && !do_write && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // ---- stage boundary: FIFO head -> master port ----
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? 32'd0 : head[31:0];
  assign m_tlast  = !empty && head[32];
  assign m_tuser  = !empty && head[33];

endmodule

// File: tb/tb_vip_gray_pixel_packer.sv
// Directed bench for vip_gray_pixel_packer with an 8x2 image and 4-word FIFO.
module tb_vip_gray_pixel_packer;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        href;
  logic        clken;
  logic [7:0]  pix_y;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;
  logic [15:0] ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vip_gray_pixel_packer #(
    .IMG_HDISP (10'd8),
    .IMG_VDISP (10'd2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(vsync),
    .per_frame_href (href),
    .per_frame_clken(clken),
    .per_img_Y      (pix_y),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tuser        (m_tuser),
    .m_tlast        (m_tlast),
    .frame_done     (frame_done),
    .ovf_cnt        (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [7:0] v);
    @(negedge clk);
    href  = 1'b1;
    clken = 1'b1;
    pix_y = v;
  endtask

  task automatic idle();
    @(negedge clk);
    href  = 1'b0;
    clken = 1'b0;
  endtask

  task automatic frame_start();
    @(negedge clk);
    vsync = 1'b0; href = 1'b0; clken = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic line8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) pix(base + 8'(i));
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; pix_y = 8'd0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rst_n = 1'b1;
    idle();

    // Full line of 8 pixels, downstream always ready.
    m_tready = 1'b1;
    frame_start();
    pix(8'h01); pix(8'h02); pix(8'h03); pix(8'h04);
    chk("l1_before_push", m_tvalid, 0);
    pix(8'h05);
    chk("l1_w0_valid", m_tvalid, 1);
    chk("l1_w0_data", m_tdata, 32'h04030201);
    chk("l1_w0_user", m_tuser, 1);
    chk("l1_w0_last", m_tlast, 0);
    pix(8'h06); pix(8'h07); pix(8'h08);
    idle();
    chk("l1_w1_valid", m_tvalid, 1);
    chk("l1_w1_data", m_tdata, 32'h08070605);
    chk("l1_w1_user", m_tuser, 0);
    chk("l1_w1_last", m_tlast, 1);
    chk("l1_no_frame_done", frame_done, 0);
    idle();
    chk("l1_drained", m_tvalid, 0);

    // Short line of 6 pixels on the last line of the frame.
    pix(8'h10); pix(8'h11); pix(8'h12); pix(8'h13);
    pix(8'h14);
    chk("sl_w0_data", m_tdata, 32'h13121110);
    chk("sl_w0_last", m_tlast, 0);
    pix(8'h15);
    idle();
    chk("sl_no_push_yet", m_tvalid, 0);
    idle();
    chk("sl_w1_valid", m_tvalid, 1);
    chk("sl_w1_data", m_tdata, 32'h00001514);
    chk("sl_w1_last", m_tlast, 1);
    chk("sl_w1_user", m_tuser, 0);
    chk("sl_frame_done", frame_done, 1);
    idle();
    chk("sl_frame_done_pulse", frame_done, 0);
    chk("sl_drained", m_tvalid, 0);

    // Stalled downstream: 6 words offered, 4 retained, 2 dropped.
    m_tready = 1'b0;
    frame_start();
    line8(8'h20); idle(); idle();
    line8(8'h28); idle(); idle();
    line8(8'h30);
    idle();
    chk("ovf_drop_frame_done", frame_done, 1);
    idle();
    chk("ovf_count", ovf_cnt, 2);
    chk("ovf_head_valid", m_tvalid, 1);
    chk("ovf_head_data", m_tdata, 32'h23222120);
    chk("ovf_head_user", m_tuser, 1);
    idle(); m_tready = 1'b1;
    chk("ovf_d0", m_tdata, 32'h23222120);
    idle();
    chk("ovf_d1", m_tdata, 32'h27262524);
    chk("ovf_d1_last", m_tlast, 1);
    idle();
    chk("ovf_d2", m_tdata, 32'h2B2A2928);
    idle();
    chk("ovf_d3", m_tdata, 32'h2F2E2D2C);
    idle();
    chk("ovf_empty", m_tvalid, 0);
    chk("ovf_count_hold", ovf_cnt, 2);

    // Full FIFO with a push and a pop in the same cycle.
    m_tready = 1'b0;
    frame_start();
    line8(8'h40); idle();
    line8(8'h48); idle();
    chk("pp_full_valid", m_tvalid, 1);
    pix(8'h50); pix(8'h51); pix(8'h52);
    pix(8'h53); m_tready = 1'b1;
    idle(); m_tready = 1'b0;
    chk("pp_ovf_same", ovf_cnt, 2);
    chk("pp_head", m_tdata, 32'h47464544);
    idle(); m_tready = 1'b1;
    chk("pp_d0", m_tdata, 32'h47464544);
    idle();
    chk("pp_d1", m_tdata, 32'h4B4A4948);
    idle();
    chk("pp_d2", m_tdata, 32'h4F4E4D4C);
    idle();
    chk("pp_d3", m_tdata, 32'h53525150);
    idle();
    chk("pp_empty", m_tvalid, 0);

    // Reset in the middle of a line.
    m_tready = 1'b0;
    frame_start();
    pix(8'h60); pix(8'h61); pix(8'h62); pix(8'h63); pix(8'h64); pix(8'h65);
    chk("mr_valid_before", m_tvalid, 1);
    @(negedge clk);
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0;
    @(negedge clk);
    chk("mr_tvalid", m_tvalid, 0);
    chk("mr_tdata", m_tdata, 0);
    chk("mr_tuser", m_tuser, 0);
    chk("mr_tlast", m_tlast, 0);
    chk("mr_ovf", ovf_cnt, 0);
    chk("mr_frame_done", frame_done, 0);
    rst_n = 1'b1;
    pix(8'h70); pix(8'h71); pix(8'h72); pix(8'h73);
    idle(); idle();
    chk("mr_no_vsync_ignored", m_tvalid, 0);
    m_tready = 1'b1;
    frame_start();
    pix(8'h80); pix(8'h81); pix(8'h82); pix(8'h83);
    pix(8'h84);
    chk("mr_new_valid", m_tvalid, 1);
    chk("mr_new_data", m_tdata, 32'h83828180);
    chk("mr_new_user", m_tuser, 1);
    idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
